// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / trap sequencing controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_DRAIN = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_MTVEC  = 2'b10,
        PC_MEPC   = 2'b11
    } pc_sel_t;

    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAK       = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_FAULT = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M     = 4'd11;

    // ecall outranks ebreak outranks illegal when several fire together
    function automatic logic [CAUSE_W-1:0] sys_cause(input logic ecall, input logic ebreak);
        if (ecall)       return CAUSE_ECALL_M;
        else if (ebreak) return CAUSE_BREAK;
        else             return CAUSE_ILLEGAL;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle: stage register fields in, stall/flush/redirect controls out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0]   id_rs1, id_rs2;
    logic               id_use_rs1, id_use_rs2;
    logic [REG_W-1:0]   ex_rd, mem_rd, wb_rd;
    logic               ex_wb, ex_L, mem_wb, wb_wb;
    logic               ex_branch_taken, ex_ecall, ex_ebreak, ex_illegal, ex_mret;
    logic               mem_req, mem_is_store, mem_ready;
    logic [1:0]         fwd_a, fwd_b, pc_sel;
    logic               stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic               trap_commit, mret_commit, mem_abort;
    logic [CAUSE_W-1:0] trap_cause;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_wb, ex_L,
               mem_rd, mem_wb, wb_rd, wb_wb, ex_branch_taken, ex_ecall, ex_ebreak,
               ex_illegal, ex_mret, mem_req, mem_is_store, mem_ready,
        input  fwd_a, fwd_b, pc_sel, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               trap_commit, mret_commit, trap_cause, mem_abort
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_wb, ex_L,
               mem_rd, mem_wb, wb_rd, wb_wb, ex_branch_taken, ex_ecall, ex_ebreak,
               ex_illegal, ex_mret, mem_req, mem_is_store, mem_ready,
        output fwd_a, fwd_b, pc_sel, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               trap_commit, mret_commit, trap_cause, mem_abort
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand bypass select for one ID source register; MEM result outranks WB, x0 never forwards.
module pipeline_hazard_ctrl_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_wb_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_wb_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_wb_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_wb_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, flush and trap sequencing controller for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT       = 16,
    parameter int unsigned TRAP_DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRAIN_W = $clog2(TRAP_DRAIN_CYCLES + 2);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 is_mret_q, is_mret_d;

    logic                 bus_stall, trap_evt, sys_evt, load_use;
    logic [1:0]           pc_sel;
    logic                 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic                 flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic                 trap_commit, mret_commit, mem_abort;
    logic [CAUSE_W-1:0]   trap_cause;

    pipeline_hazard_ctrl_fwd_unit u_fwd_a (
        .rs_i(hz.id_rs1), .mem_rd_i(hz.mem_rd), .mem_wb_i(hz.mem_wb),
        .wb_rd_i(hz.wb_rd), .wb_wb_i(hz.wb_wb), .sel_o(hz.fwd_a)
    );
    pipeline_hazard_ctrl_fwd_unit u_fwd_b (
        .rs_i(hz.id_rs2), .mem_rd_i(hz.mem_rd), .mem_wb_i(hz.mem_wb),
        .wb_rd_i(hz.wb_rd), .wb_wb_i(hz.wb_wb), .sel_o(hz.fwd_b)
    );

    assign bus_stall = hz.mem_req & ~hz.mem_ready;
    assign trap_evt  = hz.ex_ecall | hz.ex_ebreak | hz.ex_illegal;
    assign sys_evt   = trap_evt | hz.ex_mret;
    assign load_use  = hz.ex_L & hz.ex_wb & (hz.ex_rd != '0) &
                       ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                        (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            drain_q   <= '0;
            cause_q   <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            drain_q   <= drain_d;
            cause_q   <= cause_d;
            is_mret_q <= is_mret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        cause_d      = cause_q;
        is_mret_d    = is_mret_q;
        pc_sel       = PC_PLUS4;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        trap_commit  = 1'b0;
        mret_commit  = 1'b0;
        mem_abort    = 1'b0;
        trap_cause   = '0;

        unique case (state_q)
            ST_RUN: begin
                if (sys_evt && !bus_stall) begin
                    stall_pc     = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    cause_d      = trap_evt ? sys_cause(hz.ex_ecall, hz.ex_ebreak) : cause_q;
                    is_mret_d    = ~trap_evt;
                    drain_d      = DRAIN_W'(TRAP_DRAIN_CYCLES);
                    state_d      = ST_TRAP_DRAIN;
                end else if (bus_stall) begin
                    wait_d  = WAIT_W'(1);
                    state_d = ST_MEM_WAIT;
                end else if (hz.ex_branch_taken) begin
                    // a taken branch also squashes any load-use bubble on the wrong path
                    pc_sel      = PC_BRANCH;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    mem_abort    = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    flush_mem_wb = 1'b1;
                    cause_d      = hz.mem_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                    is_mret_d    = 1'b0;
                    wait_d       = '0;
                    drain_d      = DRAIN_W'(TRAP_DRAIN_CYCLES);
                    state_d      = ST_TRAP_DRAIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_TRAP_DRAIN: begin
                stall_pc    = 1'b1;
                flush_if_id = 1'b1;
                if (!bus_stall) begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        drain_d = '0;
                        state_d = ST_REDIRECT;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
            end
            ST_REDIRECT: begin
                pc_sel      = is_mret_q ? PC_MEPC : PC_MTVEC;
                trap_commit = ~is_mret_q;
                mret_commit = is_mret_q;
                trap_cause  = is_mret_q ? '0 : cause_q;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // an outstanding bus access freezes the front of the pipe in every state
        if (bus_stall) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end
    end

    assign hz.pc_sel       = pc_sel;
    assign hz.stall_pc     = stall_pc;
    assign hz.stall_if_id  = stall_if_id;
    assign hz.stall_id_ex  = stall_id_ex;
    assign hz.stall_ex_mem = stall_ex_mem;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.flush_ex_mem = flush_ex_mem;
    assign hz.flush_mem_wb = flush_mem_wb;
    assign hz.trap_commit  = trap_commit;
    assign hz.mret_commit  = mret_commit;
    assign hz.mem_abort    = mem_abort;
    assign hz.trap_cause   = trap_cause;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: cycle model compared every cycle plus literal spot checks.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int TDC         = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TRAP_DRAIN_CYCLES(TDC)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    always #5 clk = ~clk;

    // model state: cycles already spent waiting on the bus, drain cycles left, redirect due
    int m_wait = 0, m_drain = 0, m_cause = 0;
    bit m_redir = 0, m_mret = 0;
    int n_wait, n_drain, n_cause;
    bit n_redir, n_mret;
    logic [20:0] exp_vec, act_vec;

    function automatic logic [1:0] mfwd(input logic [4:0] rs);
        if (hz.mem_wb && hz.mem_rd != 5'd0 && hz.mem_rd == rs) return 2'd1;
        if (hz.wb_wb && hz.wb_rd != 5'd0 && hz.wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    assign act_vec = {hz.fwd_a, hz.fwd_b, hz.stall_pc, hz.stall_if_id, hz.stall_id_ex,
                      hz.stall_ex_mem, hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem,
                      hz.flush_mem_wb, hz.pc_sel, hz.trap_commit, hz.mret_commit,
                      hz.trap_cause, hz.mem_abort};

    always @(negedge clk) begin
        if (rst_n) begin
            logic bs, evt, trap, lu;
            logic [1:0] fa, fb, pcs;
            logic spc, sif, sid, sex, fif, fid, fex, fmw, tc, mc, ab;
            logic [3:0] cs;
            bs   = hz.mem_req && !hz.mem_ready;
            trap = hz.ex_ecall || hz.ex_ebreak || hz.ex_illegal;
            evt  = trap || hz.ex_mret;
            lu   = hz.ex_L && hz.ex_wb && hz.ex_rd != 5'd0 &&
                   ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
            fa = mfwd(hz.id_rs1); fb = mfwd(hz.id_rs2); pcs = 2'd0; cs = 4'd0;
            {spc, sif, sid, sex, fif, fid, fex, fmw, tc, mc, ab} = '0;
            n_wait = m_wait; n_drain = m_drain; n_redir = 0; n_mret = m_mret; n_cause = m_cause;
            if (m_redir) begin
                pcs = m_mret ? 2'd3 : 2'd2; tc = !m_mret; mc = m_mret;
                cs = m_mret ? 4'd0 : 4'(m_cause); fif = 1; fid = 1;
            end else if (m_drain > 0) begin
                spc = 1; fif = 1;
                if (!bs) begin n_drain = m_drain - 1; n_redir = (n_drain == 0); end
            end else if (m_wait > 0) begin
                if (hz.mem_ready) n_wait = 0;
                else if (m_wait == MEM_TIMEOUT - 1) begin
                    ab = 1; fif = 1; fid = 1; fex = 1; fmw = 1;
                    n_wait = 0; n_drain = TDC; n_mret = 0; n_cause = hz.mem_is_store ? 7 : 5;
                end else n_wait = m_wait + 1;
            end else begin
                if (evt && !bs) begin
                    spc = 1; fif = 1; fid = 1; fex = 1; n_drain = TDC; n_mret = !trap;
                    if (hz.ex_ecall) n_cause = 11;
                    else if (hz.ex_ebreak) n_cause = 3;
                    else if (hz.ex_illegal) n_cause = 2;
                end else if (bs) n_wait = 1;
                else if (hz.ex_branch_taken) begin pcs = 2'd1; fif = 1; fid = 1; end
                else if (lu) begin spc = 1; sif = 1; fid = 1; end
            end
            if (bs) begin spc = 1; sif = 1; sid = 1; sex = 1; fmw = 1; end
            exp_vec = {fa, fb, spc, sif, sid, sex, fif, fid, fex, fmw, pcs, tc, mc, cs, ab};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL model t=%0t actual=%h expected=%h", $time, act_vec, exp_vec);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 0; m_drain <= 0; m_redir <= 0; m_mret <= 0; m_cause <= 0;
        end else begin
            m_wait <= n_wait; m_drain <= n_drain; m_redir <= n_redir;
            m_mret <= n_mret; m_cause <= n_cause;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rd = 0; hz.ex_wb = 0; hz.ex_L = 0; hz.mem_rd = 0; hz.mem_wb = 0;
        hz.wb_rd = 0; hz.wb_wb = 0; hz.ex_branch_taken = 0; hz.ex_ecall = 0;
        hz.ex_ebreak = 0; hz.ex_illegal = 0; hz.ex_mret = 0;
        hz.mem_req = 0; hz.mem_is_store = 0; hz.mem_ready = 0;
    endtask

    // advance to just after the next rising edge, then clear inputs
    task automatic tick();
        @(posedge clk); #1; idle();
    endtask

    initial begin
        idle();
        #3;
        chk("reset_outputs", int'(act_vec), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // load-use bubble then forward from WB
        tick(); hz.ex_L = 1; hz.ex_wb = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
        hz.id_rs2 = 1; hz.id_use_rs2 = 1; #1;
        chk("lu_stall_pc", hz.stall_pc, 1); chk("lu_stall_if_id", hz.stall_if_id, 1);
        chk("lu_flush_id_ex", hz.flush_id_ex, 1);
        tick(); hz.id_rs1 = 5; hz.id_use_rs1 = 1; hz.id_rs2 = 1; hz.wb_rd = 5; hz.wb_wb = 1; #1;
        chk("lu_released", hz.stall_pc, 0); chk("lu_fwd_a", hz.fwd_a, 2);

        // forwarding priority and x0
        tick(); hz.mem_rd = 3; hz.mem_wb = 1; hz.wb_rd = 3; hz.wb_wb = 1; hz.id_rs2 = 3; #1;
        chk("fwd_b_mem_prio", hz.fwd_b, 1);
        tick(); hz.mem_wb = 1; hz.wb_rd = 3; hz.wb_wb = 1; hz.id_rs2 = 3; #1;
        chk("fwd_b_wb", hz.fwd_b, 2);
        tick(); hz.mem_wb = 1; hz.wb_wb = 1; #1;
        chk("fwd_b_x0", hz.fwd_b, 0);

        // branch alone, branch with load-use
        tick(); hz.ex_branch_taken = 1; #1;
        chk("br_pc_sel", hz.pc_sel, 1); chk("br_flush_id_ex", hz.flush_id_ex, 1);
        tick(); hz.ex_branch_taken = 1; hz.ex_L = 1; hz.ex_wb = 1; hz.ex_rd = 7;
        hz.id_rs1 = 7; hz.id_use_rs1 = 1; #1;
        chk("br_lu_pc_sel", hz.pc_sel, 1); chk("br_lu_no_stall", hz.stall_if_id, 0);

        // ecall with idle bus: redirect three cycles after detection
        tick(); hz.ex_ecall = 1; #1;
        chk("ecall_flush_ex_mem", hz.flush_ex_mem, 1);
        tick(); #1; chk("ecall_d1_stall_pc", hz.stall_pc, 1);
        tick(); #1; chk("ecall_d2_commit", hz.trap_commit, 0);
        tick(); #1;
        chk("ecall_pc_sel", hz.pc_sel, 2); chk("ecall_commit", hz.trap_commit, 1);
        chk("ecall_cause", hz.trap_cause, 11);
        tick(); #1; chk("ecall_commit_done", hz.trap_commit, 0);

        // mret with bus held busy for three drain cycles
        tick(); hz.ex_mret = 1; #1;
        for (int i = 0; i < 3; i++) begin tick(); hz.mem_req = 1; end
        #1; chk("mret_bus_stall", hz.stall_ex_mem, 1);
        tick(); tick(); #1; chk("mret_not_yet", hz.mret_commit, 0);
        tick(); #1;
        chk("mret_pc_sel", hz.pc_sel, 3); chk("mret_commit", hz.mret_commit, 1);
        chk("mret_no_trap", hz.trap_commit, 0);

        // short bus wait released by ready
        tick(); hz.mem_req = 1;
        tick(); hz.mem_req = 1;
        tick(); hz.mem_req = 1; hz.mem_ready = 1; #1;
        chk("ready_release", hz.stall_pc, 0);

        // store timeout: abort in the 16th stalled cycle, then store access fault
        for (int i = 1; i <= 15; i++) begin tick(); hz.mem_req = 1; hz.mem_is_store = 1; end
        #1; chk("timeout_c15", hz.mem_abort, 0);
        tick(); hz.mem_req = 1; hz.mem_is_store = 1; #1;
        chk("timeout_abort", hz.mem_abort, 1); chk("timeout_flush_mem_wb", hz.flush_mem_wb, 1);
        tick(); tick(); tick(); #1;
        chk("fault_commit", hz.trap_commit, 1); chk("fault_cause", hz.trap_cause, 7);

        // branch and illegal together: trap wins
        tick(); hz.ex_branch_taken = 1; hz.ex_illegal = 1; #1;
        chk("br_ill_pc_sel", hz.pc_sel, 0); chk("br_ill_flush_ex_mem", hz.flush_ex_mem, 1);
        tick(); tick(); tick(); #1;
        chk("ill_pc_sel", hz.pc_sel, 2); chk("ill_cause", hz.trap_cause, 2);

        // reset during drain discards the trap
        tick(); hz.ex_ebreak = 1;
        tick(); #1; rst_n = 1'b0; #1;
        chk("rst_mid_trap_outputs", int'(act_vec), 0);
        tick(); tick(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); #1; chk("rst_no_commit", int'(hz.trap_commit | hz.mret_commit), 0);
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB) that sits beside the instruction decoder.
- Detects load-use hazards and drives operand forwarding selects.
- Applies branch/jump flushes and holds the pipeline while the data bus is busy.
- Sequences trap entry (ecall/ebreak/illegal/bus timeout) and mret return through a small FSM that drains older instructions before redirecting the PC.

Parameters:
MEM_TIMEOUT, 16, cycles a MEM-stage request may wait for mem_ready before it is aborted as an access fault
TRAP_DRAIN_CYCLES, 2, non-stalled cycles to wait after trap detection before redirect (lets MEM and WB retire)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
ex_rd  in  5  destination of EX instruction; ex_wb  in  1  writes back; ex_L  in  1  is a load
mem_rd  in  5  / mem_wb  in  1  MEM-stage destination and writeback enable
wb_rd  in  5  / wb_wb  in  1  WB-stage destination and writeback enable
ex_branch_taken  in  1  taken branch or jump resolved in EX
ex_ecall, ex_ebreak, ex_illegal, ex_mret  in  1  system events of the instruction in EX
mem_req  in  1  load/store active in MEM; mem_is_store  in  1  it is a store; mem_ready  in  1  bus completes this cycle
fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 MEM result, 10 WB result
stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the register
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1  load bubble
pc_sel  out  2  00 pc+4, 01 branch target, 10 mtvec, 11 mepc
trap_commit  out  1  one-cycle pulse: CSR file writes mepc/mcause
mret_commit  out  1  one-cycle pulse: CSR file restores mstatus
trap_cause  out  4  mcause code, valid with trap_commit
mem_abort  out  1  one-cycle pulse: bus request abandoned

Behaviour:
- FSM states are RUN, MEM_WAIT, TRAP_DRAIN and REDIRECT.
- Reset: state RUN, wait_cnt=0, drain_cnt=0, cause reg=0, is_mret=0; every output 0.
- Reset asserted mid-trap discards the pending trap; no commit pulse is emitted.
- Forwarding is combinational in all states.
  - fwd_a=01 if mem_wb & mem_rd!=0 & mem_rd==id_rs1; else 10 if wb_wb & wb_rd!=0 & wb_rd==id_rs1; else 00. fwd_b uses the same rule on id_rs2.
  - MEM has priority over WB.
- Bus stall: any cycle with mem_req & !mem_ready asserts stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and flush_mem_wb. This overrides every RUN action below.
- RUN, in priority order:
  1. ex_ecall|ex_ebreak|ex_illegal|ex_mret, with no bus stall: flush_if_id, flush_id_ex, flush_ex_mem, stall_pc. Latch cause (ecall 11, ebreak 3, illegal 2) and is_mret. drain_cnt<=TRAP_DRAIN_CYCLES. Go to TRAP_DRAIN.
  2. Bus stall: go to MEM_WAIT with wait_cnt<=1.
  3. ex_branch_taken: pc_sel=01, flush_if_id, flush_id_ex.
  4. Load-use (ex_L & ex_wb & ex_rd!=0 & rs match with use flag): stall_pc, stall_if_id, flush_id_ex. The bubble costs exactly 1 cycle.
- MEM_WAIT:
  - mem_ready=1: stall released that same cycle; go to RUN, wait_cnt<=0.
  - wait_cnt==MEM_TIMEOUT-1 with no ready: pulse mem_abort; cause<=mem_is_store?7:5; flush all four registers; go to TRAP_DRAIN.
  - Otherwise wait_cnt increments.
- TRAP_DRAIN:
  - stall_pc held, flush_if_id held.
  - drain_cnt decrements only in cycles with no bus stall.
  - On reaching 0, go to REDIRECT.
- REDIRECT (exactly 1 cycle):
  - pc_sel = is_mret?11:10.
  - Pulse trap_commit with trap_cause when !is_mret; pulse mret_commit when is_mret.
  - flush_if_id, flush_id_ex; go to RUN.
- Trap-entry latency from detection to redirect is TRAP_DRAIN_CYCLES+1 cycles when the bus is idle.
- Simultaneous taken branch and trap: trap wins.
- Branch and load-use together: branch wins, since the stalled instruction is on the wrong path.
- x0 is never a hazard or forwarding source.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - fwd select codes.
  - pc_sel codes.
  - mcause constants: CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_LOAD_FAULT=5, CAUSE_STORE_FAULT=7, CAUSE_ECALL_M=11.
- One natural sub-module, fwd_unit: the combinational forwarding comparators, instantiated once per operand.

Test Plan:
- lw x5 in EX with add x6,x5,x1 in ID -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle; next cycle fwd_a=10.
- mem_rd=3/mem_wb=1 and wb_rd=3/wb_wb=1 with id_rs2=3 -> fwd_b=01; with rd=0 -> fwd_b=00.
- ex_ecall=1, bus idle -> TRAP_DRAIN 2 cycles, then REDIRECT: pc_sel=10, trap_commit=1, trap_cause=11 in cycle 3.
- ex_mret=1 while mem_ready is held low for 3 cycles -> drain extends by 3; REDIRECT has pc_sel=11 and mret_commit=1.
- mem_req=1, mem_is_store=1, mem_ready=0 for 16 cycles -> mem_abort at cycle 16, then trap_commit with trap_cause=7.
- ex_branch_taken with ex_illegal in the same cycle -> trap path taken, pc_sel never 01; reset asserted in TRAP_DRAIN -> state RUN, no commit pulse.
